fsm_state_monitor: RTL
======================

Name: fsm_state_monitor

Overview:
- Downstream observer of the one-hot IDLE/BUSY/WAIT job-control state machine; consumes its 3-bit state output every cycle.
- Accumulates per-state occupancy, completed-job count and last job length, and flags illegal encodings/transitions and BUSY overruns.
- Results are exposed to status/debug logic. Pure observer: never back-pressures the FSM.

Parameters:
- CNT_WIDTH, 16, width of all occupancy/job counters (saturating).
- TIMEOUT, 1024, consecutive BUSY samples that trigger o_timeout; legal range 1..2**CNT_WIDTH-1.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset; synchronous, active-high.
- i_state  input  3  observed state, one-hot: IDLE=3'b001, BUSY=3'b010, WAIT=3'b100.
- i_clear  input  1  synchronous clear of statistics and sticky flags.
- o_idle_cycles  output  CNT_WIDTH  samples with i_state==IDLE.
- o_busy_cycles  output  CNT_WIDTH  samples with i_state==BUSY.
- o_wait_cycles  output  CNT_WIDTH  samples with i_state==WAIT.
- o_job_count  output  CNT_WIDTH  completed jobs (BUSY->IDLE transitions).
- o_last_job_len  output  CNT_WIDTH  BUSY+WAIT samples of the most recently completed job.
- o_illegal  output  1  sticky: illegal encoding or illegal transition seen.
- o_timeout  output  1  sticky: BUSY held for TIMEOUT consecutive samples.

Behaviour:
- All outputs registered. A sample on cycle N is reflected in outputs from cycle N+1.
- Reset (i_rst high at a clock edge): all outputs 0, job length accumulator 0, BUSY run counter 0, prev-state register = IDLE.
- Reset mid-job discards all in-flight data.
- Legal encodings: exactly one bit set.
- Legal transitions (prev->cur): any self-loop, IDLE->BUSY, WAIT->BUSY, BUSY->WAIT, BUSY->IDLE.
- Illegal transitions: IDLE->WAIT, WAIT->IDLE.
- Legal-encoding sample:
  - Increment the matching occupancy counter.
  - Update prev-state.
  - Illegal transition sets o_illegal; counting proceeds normally.
- Non-one-hot sample (000, 011, 101, 110, 111):
  - Set o_illegal.
  - No counter, accumulator or run-counter change.
  - prev-state holds.
- Job tracking:
  - Accumulator increments on every BUSY or WAIT sample.
  - On a BUSY->IDLE sample: o_last_job_len <= accumulator value, o_job_count += 1, accumulator <= 0.
  - WAIT->IDLE (illegal) does not complete a job; accumulator clears.
- Timeout:
  - Run counter increments on each BUSY sample and clears on any legal non-BUSY sample.
  - When a BUSY sample brings the run count to TIMEOUT, o_timeout sets.
  - Run counter saturates at TIMEOUT.
- Saturation: every counter and the accumulator saturate at all-ones, with no wrap. o_last_job_len captures the saturated value.
- i_clear:
  - Zeros all outputs, the accumulator and the run counter.
  - prev-state still updates from the current sample, so transition checking stays valid.
  - Clear has priority over any same-cycle increment or flag set; that sample is not counted.
- i_rst has priority over i_clear.

Test Plan:
1. Reset, then IDLE x3, BUSY x4, WAIT x2, BUSY x1, IDLE x1 -> idle=4, busy=5, wait=2, job_count=1, last_job_len=7, illegal=0, timeout=0.
2. CNT_WIDTH=4: IDLE x20 -> o_idle_cycles=15 and holds. BUSY x20 then IDLE -> last_job_len=15, job_count=1.
3. IDLE, then i_state=3'b011 for 1 cycle, then IDLE -> o_illegal=1 from the cycle after 011, idle count excludes that sample. Separately, IDLE then WAIT -> o_illegal=1, wait=1.
4. TIMEOUT=8: BUSY x7, WAIT x1, BUSY x7 -> timeout=0. BUSY x8 -> o_timeout=1 the cycle after the 8th BUSY sample, and it stays 1 after returning to IDLE.
5. Mid-job (BUSY x3), pulse i_clear on a BUSY sample, then BUSY x2, IDLE -> all counters restart. After that sequence: busy=2, last_job_len=2, job_count=1, idle=1.
6. Mid-job, assert i_rst and i_clear together, then BUSY x2, IDLE -> all outputs 0 after reset, then last_job_len=2, job_count=1.

Source files
------------

// File: rtl/fsm_state_monitor.sv
// ---------------------------------------------------------------------------
// fsm_state_monitor
//
// Passive observer of a one-hot IDLE/BUSY/WAIT job-control state machine.
// The monitor samples the observed state every clock and keeps these results:
//   - per-state occupancy counts
//   - the number of completed jobs and the length of the last job
//   - sticky flags for illegal encodings/transitions and for BUSY overruns
// It never drives anything back toward the observed FSM.
//
// Ports
//   i_clk          : clock
//   i_rst          : synchronous active-high reset; has priority over i_clear
//   i_state[2:0]   : observed state, IDLE=001, BUSY=010, WAIT=100
//   i_clear        : synchronous clear of statistics and sticky flags
//   o_idle_cycles  : number of IDLE samples (saturating)
//   o_busy_cycles  : number of BUSY samples (saturating)
//   o_wait_cycles  : number of WAIT samples (saturating)
//   o_job_count    : number of completed jobs, i.e. BUSY->IDLE (saturating)
//   o_last_job_len : BUSY+WAIT samples in the most recently completed job
//   o_illegal      : sticky flag, set on an illegal encoding or transition
//   o_timeout      : sticky flag, set when BUSY is held for TIMEOUT samples
//
// All outputs are registered. A sample taken on cycle N is visible from
// cycle N+1.
// ---------------------------------------------------------------------------
module fsm_state_monitor #(
   parameter int CNT_WIDTH = 16,
   parameter int TIMEOUT   = 1024
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [2:0]           i_state,
   input  logic                 i_clear,
   output logic [CNT_WIDTH-1:0] o_idle_cycles,
   output logic [CNT_WIDTH-1:0] o_busy_cycles,
   output logic [CNT_WIDTH-1:0] o_wait_cycles,
   output logic [CNT_WIDTH-1:0] o_job_count,
   output logic [CNT_WIDTH-1:0] o_last_job_len,
   output logic                 o_illegal,
   output logic                 o_timeout
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_BUSY = 3'b010,
      ST_WAIT = 3'b100
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = '0;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);

   // Saturating increment: once a counter reaches all-ones it holds there
   // instead of wrapping back to zero.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      sat_inc = (&v) ? v : v + CNT_ONE;
   endfunction

   // Returns 1 when exactly one of the three state bits is set.
   function automatic logic is_onehot3(input logic [2:0] s);
      case (s)
         3'b001, 3'b010, 3'b100: is_onehot3 = 1'b1;
         default:                is_onehot3 = 1'b0;
      endcase
   endfunction

   state_t                prev_q,    prev_d;
   logic [CNT_WIDTH-1:0]  idle_q,    idle_d;
   logic [CNT_WIDTH-1:0]  busy_q,    busy_d;
   logic [CNT_WIDTH-1:0]  wait_q,    wait_d;
   logic [CNT_WIDTH-1:0]  job_q,     job_d;
   logic [CNT_WIDTH-1:0]  last_q,    last_d;
   logic [CNT_WIDTH-1:0]  acc_q,     acc_d;
   logic [CNT_WIDTH-1:0]  run_q,     run_d;
   logic                  illegal_q, illegal_d;
   logic                  timeout_q, timeout_d;

   logic                  legal_enc;
   logic                  bad_trans;
   logic [CNT_WIDTH-1:0]  run_inc;

   always_comb begin
      prev_d    = prev_q;
      idle_d    = idle_q;
      busy_d    = busy_q;
      wait_d    = wait_q;
      job_d     = job_q;
      last_d    = last_q;
      acc_d     = acc_q;
      run_d     = run_q;
      illegal_d = illegal_q;
      timeout_d = timeout_q;

      legal_enc = is_onehot3(i_state);
      // Only two transitions are illegal. IDLE->WAIT and WAIT->IDLE skip
      // BUSY.
      bad_trans = ((prev_q == ST_IDLE) && (i_state == ST_WAIT)) ||
                  ((prev_q == ST_WAIT) && (i_state == ST_IDLE));
      // The BUSY run counter stops at TIMEOUT, so it never has to
      // saturate at all-ones on its own.
      run_inc   = (run_q >= TIMEOUT_C) ? TIMEOUT_C : run_q + CNT_ONE;

      if (i_clear) begin
         // Clear wins over every increment and flag set for this sample.
         // The previous-state register still follows a legal sample, so the
         // next transition check stays meaningful.
         idle_d    = CNT_ZERO;
         busy_d    = CNT_ZERO;
         wait_d    = CNT_ZERO;
         job_d     = CNT_ZERO;
         last_d    = CNT_ZERO;
         acc_d     = CNT_ZERO;
         run_d     = CNT_ZERO;
         illegal_d = 1'b0;
         timeout_d = 1'b0;
         if (legal_enc) begin
            prev_d = state_t'(i_state);
         end
      end else if (!legal_enc) begin
         // A corrupt encoding is flagged and otherwise ignored. All counters
         // and prev_q keep their values.
         illegal_d = 1'b1;
      end else begin
         prev_d = state_t'(i_state);
         if (bad_trans) begin
            illegal_d = 1'b1;
         end
         case (i_state)
            3'b001: begin
               idle_d = sat_inc(idle_q);
               run_d  = CNT_ZERO;
               // Only BUSY->IDLE completes a job. A WAIT->IDLE sample
               // abandons the job in progress.
               acc_d  = CNT_ZERO;
               if (prev_q == ST_BUSY) begin
                  last_d = acc_q;
                  job_d  = sat_inc(job_q);
               end
            end
            3'b010: begin
               busy_d = sat_inc(busy_q);
               acc_d  = sat_inc(acc_q);
               run_d  = run_inc;
               if (run_inc == TIMEOUT_C) begin
                  timeout_d = 1'b1;
               end
            end
            3'b100: begin
               wait_d = sat_inc(wait_q);
               acc_d  = sat_inc(acc_q);
               run_d  = CNT_ZERO;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         prev_q    <= ST_IDLE;
         idle_q    <= CNT_ZERO;
         busy_q    <= CNT_ZERO;
         wait_q    <= CNT_ZERO;
         job_q     <= CNT_ZERO;
         last_q    <= CNT_ZERO;
         acc_q     <= CNT_ZERO;
         run_q     <= CNT_ZERO;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         prev_q    <= prev_d;
         idle_q    <= idle_d;
         busy_q    <= busy_d;
         wait_q    <= wait_d;
         job_q     <= job_d;
         last_q    <= last_d;
         acc_q     <= acc_d;
         run_q     <= run_d;
         illegal_q <= illegal_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_idle_cycles  = idle_q;
   assign o_busy_cycles  = busy_q;
   assign o_wait_cycles  = wait_q;
   assign o_job_count    = job_q;
   assign o_last_job_len = last_q;
   assign o_illegal      = illegal_q;
   assign o_timeout      = timeout_q;

endmodule
